i2c_fifo_master: RTL

Sequences the FIFO-to-I2C datapath in the SPI/I2C bridge. Pops bytes from the async FIFO read port (rd_data/rd_empty/rd_en) in the rd_clk domain and frames them as I2C master write transactions: START, address+W, data bytes, STOP. It is the single owner of rd_en, scl and sda. It guarantees no pop while the FIFO is empty, and no scl/sda activity outside a transaction.

---
 rtl/i2c_fifo_master_if.sv | 26 ++
 rtl/i2c_fifo_master.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_fifo_master_if.sv
// Bus bundle between the FIFO/I2C sequencer and its environment: FIFO read
// port, I2C pin controls and status.
interface i2c_fifo_master_if;
    logic       enable;
    logic [7:0] rd_data;
    logic       rd_empty;
    logic       rd_en;
    logic       scl;
    logic       sda_o;
    logic       sda_oe;
    logic       sda_i;
    logic       busy;
    logic       done;
    logic       nack_err;
    logic [7:0] byte_cnt;

    modport master (
        input  enable, rd_data, rd_empty, sda_i,
        output rd_en, scl, sda_o, sda_oe, busy, done, nack_err, byte_cnt
    );

    modport slave (
        output enable, rd_data, rd_empty, sda_i,
        input  rd_en, scl, sda_o, sda_oe, busy, done, nack_err, byte_cnt
    );
endinterface

// File: rtl/i2c_fifo_master.sv
// Pops bytes from the FIFO read port and frames them as I2C master write
// transactions (START, address+W, data bytes, STOP) on open-drain SCL/SDA.
module i2c_fifo_master #(
    parameter int unsigned CLK_DIV   = 250,
    parameter logic [6:0]  DEV_ADDR  = 7'h50,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    i2c_fifo_master_if.master bus
);
    localparam int unsigned   TW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
    localparam logic [7:0]    BURST_MAX = 8'(MAX_BURST);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_FETCH,
        S_LOAD, S_DATA, S_DATA_ACK, S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          ack_q, ack_d;
    logic [7:0]    byte_cnt_q, byte_cnt_d;
    logic          nack_err_q, nack_err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          scl_q, scl_d;
    logic          sda_oe_q, sda_oe_d;

    logic timed;
    logic tick;
    logic fetch_ok;

    // The quarter-tick counter only runs in states that drive the bus timing.
    assign timed = (state_q != S_IDLE) && (state_q != S_FETCH) && (state_q != S_LOAD);
    assign tick  = timed && (tick_cnt_q == TICK_LAST);

    assign fetch_ok = bus.enable && !bus.rd_empty && (byte_cnt_q < BURST_MAX);

    always_comb begin
        tick_cnt_d = '0;
        if (timed && !tick) begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        qtr_d      = qtr_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        ack_d      = ack_q;
        byte_cnt_d = byte_cnt_q;
        nack_err_d = nack_err_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.enable && !bus.rd_empty) begin
                    state_d    = S_START;
                    qtr_d      = 2'd0;
                    bit_d      = 3'd0;
                    shift_d    = {DEV_ADDR, 1'b0};
                    nack_err_d = 1'b0;
                    byte_cnt_d = 8'd0;
                    busy_d     = 1'b1;
                end
            end
            S_START: begin
                if (tick) begin
                    if (qtr_q == 2'd2) begin
                        state_d = S_ADDR;
                        qtr_d   = 2'd0;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            S_ADDR, S_DATA: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
                        end
                    end
                end
            end
            S_ADDR_ACK, S_DATA_ACK: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd2) begin
                        ack_d = bus.sda_i;
                    end
                    if (qtr_q == 2'd3) begin
                        if (!ack_q) begin
                            state_d = S_FETCH;
                            if (state_q == S_DATA_ACK && byte_cnt_q < BURST_MAX) begin
                                byte_cnt_d = byte_cnt_q + 8'd1;
                            end
                        end else begin
                            state_d    = S_STOP;
                            nack_err_d = 1'b1;
                        end
                    end
                end
            end
            S_FETCH: begin
                qtr_d   = 2'd0;
                state_d = fetch_ok ? S_LOAD : S_STOP;
            end
            S_LOAD: begin
                shift_d = bus.rd_data;
                bit_d   = 3'd0;
                qtr_d   = 2'd0;
                state_d = S_DATA;
            end
            S_STOP: begin
                if (tick) begin
                    if (qtr_q == 2'd2) begin
                        state_d = S_IDLE;
                        qtr_d   = 2'd0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pin levels are decoded from the next state so SCL/SDA come straight
    // from flops and move on the same edge as the state they belong to.
    always_comb begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        case (state_d)
            S_START: begin
                scl_d    = (qtr_d != 2'd2);
                sda_oe_d = (qtr_d != 2'd0);
            end
            S_ADDR, S_DATA: begin
                scl_d    = qtr_d[1];
                sda_oe_d = ~shift_d[7];
            end
            S_ADDR_ACK, S_DATA_ACK: begin
                scl_d    = qtr_d[1];
                sda_oe_d = 1'b0;
            end
            S_FETCH, S_LOAD: begin
                scl_d    = 1'b0;
                sda_oe_d = 1'b0;
            end
            S_STOP: begin
                scl_d    = (qtr_d != 2'd0);
                sda_oe_d = (qtr_d != 2'd2);
            end
            default: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            qtr_q      <= 2'd0;
            bit_q      <= 3'd0;
            shift_q    <= 8'd0;
            ack_q      <= 1'b0;
            byte_cnt_q <= 8'd0;
            nack_err_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            ack_q      <= ack_d;
            byte_cnt_q <= byte_cnt_d;
            nack_err_q <= nack_err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            scl_q      <= scl_d;
            sda_oe_q   <= sda_oe_d;
        end
    end

    assign bus.rd_en    = (state_q == S_FETCH) && fetch_ok && !rd_rst;
    assign bus.scl      = scl_q;
    assign bus.sda_o    = 1'b0;
    assign bus.sda_oe   = sda_oe_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.nack_err = nack_err_q;
    assign bus.byte_cnt = byte_cnt_q;

endmodule
